// File: rtl/mod_inv.sv
// ---------------------------------------------------------------------------
// mod_inv -- modular inverse z_inv = z3^-1 mod p (binary extended Euclid).
//
// One reduction step per clock. Invariants kept throughout the run:
//   x1*z3 == u (mod p),  x2*z3 == v (mod p),  x1, x2 in [0, pm-1].
// When u or v reaches 1, the matching x register holds the inverse.
// If u or v reaches 0 first, the operand was not invertible and the result
// is 0.
//
// Ports:
//   clk      in   sole clock, rising edge
//   nrst     in   asynchronous reset, active-high (1 = reset)
//   flag     in   start strobe, accepted only in IDLE
//   z3       in   W  operand a, 1..p-1
//   p        in   W  odd modulus >= 3
//   z_inv    out  W  result, valid from the inv_done cycle until the next start
//   inv_done out  one-cycle completion pulse
//   err      out  (only with MOD_INV_ERR_EN) 1 when the result is 0
//   busy     out  high while in RUN or DONE
//
// Optional feature macro: MOD_INV_ERR_EN (adds the err output).
// ---------------------------------------------------------------------------
module mod_inv #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         flag,
  input  logic [W-1:0] z3,
  input  logic [W-1:0] p,
  output logic [W-1:0] z_inv,
  output logic         inv_done,
`ifdef MOD_INV_ERR_EN
  output logic         err,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         w_start;
  logic         w_term;

  logic [W-1:0] r_u;
  logic [W-1:0] r_v;
  logic [W-1:0] r_x1;
  logic [W-1:0] r_x2;
  logic [W-1:0] r_pm;
  logic [W-1:0] r_z_inv;
  logic         r_inv_done;
  logic         w_u_one;
  logic         w_v_one;

  // Halve x modulo m (m odd): an odd x is first made even by adding m.
  // The sum needs W+1 bits because x + m can exceed 2^W.
  function automatic logic [W-1:0] f_half(input logic [W-1:0] x,
                                          input logic [W-1:0] m);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[W:1];
  endfunction

  // (a - b) mod m for a, b already in [0, m-1].
  function automatic logic [W-1:0] f_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] m);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + {1'b0, m};
    return d[W-1:0];
  endfunction

  assign w_u_one = (r_u == W'(1));
  assign w_v_one = (r_v == W'(1));
  assign w_term  = w_u_one || w_v_one || (r_u == '0) || (r_v == '0);

  // State register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next state and status outputs
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        // The completion pulse cycle is already IDLE; a start seen in that
        // same cycle is dropped so the pulse never overlaps a new run.
        if (flag && !r_inv_done) begin
          w_start      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_term) w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: one Euclid step per RUN cycle
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_u  <= '0;
      r_v  <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_pm <= '0;
    end else if (w_start) begin
      r_u  <= z3;
      r_v  <= p;
      r_x1 <= W'(1);
      r_x2 <= '0;
      r_pm <= p;
    end else if (r_state == RUN && !w_term) begin
      if (!r_u[0]) begin
        r_u  <= r_u >> 1;
        r_x1 <= f_half(r_x1, r_pm);
      end else if (!r_v[0]) begin
        r_v  <= r_v >> 1;
        r_x2 <= f_half(r_x2, r_pm);
      end else if (r_u >= r_v) begin
        r_u  <= r_u - r_v;
        r_x1 <= f_sub(r_x1, r_x2, r_pm);
      end else begin
        r_v  <= r_v - r_u;
        r_x2 <= f_sub(r_x2, r_x1, r_pm);
      end
    end
  end

  // Result registers: loaded while in DONE, visible together with the pulse
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_z_inv    <= '0;
      r_inv_done <= 1'b0;
    end else begin
      r_inv_done <= (r_state == DONE);
      if (r_state == DONE) begin
        if (w_u_one)      r_z_inv <= r_x1;
        else if (w_v_one) r_z_inv <= r_x2;
        else              r_z_inv <= '0;
      end
    end
  end

`ifdef MOD_INV_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst)                  r_err <= 1'b0;
    else if (r_state == DONE)  r_err <= !(w_u_one || w_v_one);
  end
  assign err = r_err;
`endif

  assign z_inv    = r_z_inv;
  assign inv_done = r_inv_done;

endmodule

// File: tb/tb_mod_inv.sv
module tb_mod_inv;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         nrst;
  logic         flag;
  logic [W-1:0] z3;
  logic [W-1:0] p;
  logic [W-1:0] z_inv;
  logic         inv_done;
  logic         busy;
`ifdef MOD_INV_ERR_EN
  logic         err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_inv #(.W(W)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .flag     (flag),
    .z3       (z3),
    .p        (p),
    .z_inv    (z_inv),
    .inv_done (inv_done),
`ifdef MOD_INV_ERR_EN
    .err      (err),
`endif
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start strobe; returns #1 after the flag-sampling edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] m);
    @(posedge clk); #1;
    z3 = a; p = m; flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
  endtask

  // Count edges until inv_done is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (inv_done) begin
        lat = k;
        break;
      end
    end
    total++;
    assert (lat != -1) else begin
      bad++;
      $error("FAIL timeout: observed=no inv_done expected=inv_done within 1100 cycles");
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] m,
                        input logic [W-1:0] exp, input logic exp_err, output int lat);
    start(a, m);
    check({tag, "_busy"}, W'(busy), W'(1));
    wait_done(lat);
    check({tag, "_zinv"}, z_inv, exp);
`ifdef MOD_INV_ERR_EN
    check({tag, "_err"}, W'(err), W'(exp_err));
`else
    if (exp_err) begin end
`endif
    check({tag, "_busy_at_done"}, W'(busy), W'(0));
    $display("op %s z3=%0d p=%0d z_inv=%0d lat=%0d", tag, a, m, z_inv, lat);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, W'(inv_done), W'(0));
    check({tag, "_busy_after"}, W'(busy), W'(0));
  endtask

  initial begin
    int lat;
    int extra;
    logic [W-1:0]   pr;
    logic [W-1:0]   zr;
    logic [2*W-1:0] prod;
    int small_p[10] = '{3, 5, 7, 11, 13, 31, 97, 101, 251, 65521};

    nrst = 1'b1; flag = 1'b0; z3 = '0; p = '0;
    #1;
    check("rst_zinv", z_inv, '0);
    check("rst_done", W'(inv_done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1 nrst = 1'b0;

    // Directed vectors
    run_op("27_29", W'(27), W'(29), W'(14), 1'b0, lat);
    run_op("0_29",  W'(0),  W'(29), W'(0),  1'b1, lat);
    run_op("9_29",  W'(9),  W'(29), W'(13), 1'b0, lat);
    run_op("5_15",  W'(5),  W'(15), W'(0),  1'b1, lat);
    run_op("1_29",  W'(1),  W'(29), W'(1),  1'b0, lat);
    check("lat_z3_1", W'(lat), W'(2));
    run_op("27_29b", W'(27), W'(29), W'(14), 1'b0, lat);
    check("lat_27_29", W'(lat), W'(4));

    // Restart attempt mid-RUN must be ignored
    start(W'(27), W'(29));
    z3 = W'(9); flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
    wait_done(lat);
    check("restart_zinv", z_inv, W'(14));
    $display("op restart z3=27 p=29 z_inv=%0d", z_inv);
    // Start in the inv_done cycle must be ignored as well
    flag = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      flag = 1'b0;
      if (inv_done || busy) extra++;
    end
    check("no_extra_pulse", W'(extra), W'(0));

    // Reset mid-RUN (previous z_inv is 14, so zeroing is visible)
    start(W'(27), W'(29));
    nrst = 1'b1;
    #1;
    check("midrst_zinv", z_inv, '0);
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(inv_done), W'(0));
    @(posedge clk); #1 nrst = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (inv_done || busy) extra++;
    end
    check("midrst_no_pulse", W'(extra), W'(0));
    $display("op reset_mid_run");
    run_op("27_29_after_rst", W'(27), W'(29), W'(14), 1'b0, lat);

    // Random operands against large and small primes
    for (int i = 0; i < 30; i++) begin
      if (i < 10)      pr = (W'(1) << 255) - W'(19);
      else if (i < 20) pr = {W{1'b1}} - (W'(1) << 32) - W'(976);
      else             pr = W'(small_p[i-20]);
      if (i < 20) begin
        zr = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        zr = zr % pr;
        if (zr == '0) zr = W'(1);
      end else begin
        zr = W'($urandom_range(1, small_p[i-20] - 1));
      end
      start(zr, pr);
      wait_done(lat);
      prod = {{W{1'b0}}, z_inv} * {{W{1'b0}}, zr};
      prod = prod % {{W{1'b0}}, pr};
      check("rand_inverse", prod[W-1:0], W'(1));
      check("rand_lat_ok", W'(lat >= 2 && lat <= 4*W+2), W'(1));
      $display("op rand%0d z_inv*z3 mod p=%0h lat=%0d", i, prod[W-1:0], lat);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 Parameter W, default 256, operand width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 flag  input  1  start strobe, sampled on rising clk.
REQ-005 z3  input  W  operand a, the Jacobian Z coordinate; legal range 1..p-1.
REQ-006 p  input  W  modulus; odd, >= 3.
REQ-007 z_inv  output  W  result a^-1 mod p; feeds the Jacobian-to-affine x/y conversion stages.
REQ-008 inv_done  output  1  one-cycle pulse; z_inv valid from this cycle until the next accepted start.
REQ-009 busy  output  1  high while a computation is in progress (RUN or DONE).

Function
REQ-010 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-011 IDLE and flag=1: latch u<=z3, v<=p, x1<=1, x2<=0, pm<=p; go RUN; busy=1 from the next cycle.
REQ-012 flag while in RUN or DONE is ignored; inputs are not re-sampled and the operation is not restarted.
REQ-013 RUN performs exactly one step per cycle, in this priority order:
- u==1 or v==1 or u==0 or v==0: go DONE;
- u even: u<=u>>1; x1<=x1>>1 if x1 even, else (x1+pm)>>1;
- else v even: v<=v>>1; x2 updated by the same rule;
- else u>=v: u<=u-v, x1<=x1-x2 mod pm;
- else: v<=v-u, x2<=x2-x1 mod pm.
REQ-014 All intermediate sums are carried at W+1 bits; x1 and x2 stay in [0, pm-1] at all times.
REQ-015 DONE lasts exactly one cycle: inv_done=1 and z_inv loaded with x1 if u==1, x2 if v==1 (u takes priority), else 0; then go IDLE with busy=0.
REQ-016 z_inv holds its value in IDLE until the next DONE.
REQ-017 Latency from the flag-sampling edge to the inv_done-high cycle is at most 4*W+2 cycles; for z3==1 it is exactly 2 cycles.
REQ-018 z3==0 or gcd(z3,p)!=1: terminates via the u==0/v==0 condition; z_inv=0.
REQ-019 flag asserted in the same cycle inv_done is high is ignored; a new start is accepted only from IDLE.

Reset
REQ-020 nrst=1 forces, asynchronously: state IDLE, z_inv=0, inv_done=0, busy=0, u=v=x1=x2=pm=0 (err=0 when present).
REQ-021 Reset asserted mid-RUN aborts the operation with no inv_done pulse; after release the block waits for a new flag.

Configuration
REQ-022 Macro MOD_INV_ERR_EN defined: adds output port err (1 bit), loaded in DONE with 1 when the result is 0 per REQ-018, else 0, and held until the next DONE.
REQ-023 MOD_INV_ERR_EN undefined: port err is absent; all other behaviour is identical, including z_inv=0 for non-invertible inputs.

Verification
REQ-024 z3=27, p=29, flag pulse -> single inv_done pulse, z_inv=14, busy low in the following cycle.
REQ-025 z3=9, p=29 -> z_inv=13; z3=1, p=29 -> z_inv=1 with inv_done exactly 2 cycles after flag is sampled.
REQ-026 z3=0, p=29 -> z_inv=0, err=1 (with MOD_INV_ERR_EN); z3=5, p=15 -> z_inv=0, err=1.
REQ-027 flag re-pulsed mid-RUN with different z3 -> result is still that of the original operand; exactly one inv_done pulse.
REQ-028 nrst pulsed mid-RUN -> outputs zero immediately, no inv_done; a new flag with z3=27, p=29 -> z_inv=14.
REQ-029 W=256, 1000 random p (odd prime) and z3 in 1..p-1 -> (z_inv*z3) mod p == 1 each time, latency <= 1026 cycles.
